elastic_pe_ctx: RTL

Parametrised elastic processing element for the elastic CGRA simulator. It generalises the fixed-size elastic PE to any neighbour fan-in, fan-out, context depth and output-buffer depth. It adds three behaviours: a per-context repeat count, an eager per-output fork with a per-context output mask, and fire/stall performance counters. It sits in the PE array and talks to its neighbours over the SELF valid/stop protocol; a transfer happens when valid=1 and stop=0 in the same cycle.

---
 rtl/elastic_pe_ctx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/elastic_pe_ctx.sv
// Elastic CGRA processing element: per-context config memory, repeat counts,
// an eager per-output fork at the head of a small result FIFO, and fire/stall counters.
module elastic_pe_ctx #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int CTX_DEPTH  = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CTX_W      = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1,
    parameter int SEL_W      = $clog2(NUM_IN + 2)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_we,
    input  logic [CTX_W-1:0]              cfg_addr,
    input  logic [SEL_W-1:0]              cfg_src_a,
    input  logic [SEL_W-1:0]              cfg_src_b,
    input  logic [2:0]                    cfg_op,
    input  logic [DATA_WIDTH-1:0]         cfg_const,
    input  logic [NUM_OUT-1:0]            cfg_out_mask,
    input  logic [7:0]                    cfg_repeat,
    input  logic [CTX_W-1:0]              last_ctx,
    input  logic                          start,
    input  logic                          halt,
    input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]             in_valid,
    output logic [NUM_IN-1:0]             in_stop,
    output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]            out_valid,
    input  logic [NUM_OUT-1:0]            out_stop,
    output logic [CTX_W-1:0]              ctx_id,
    output logic                          busy,
    output logic [31:0]                   fire_count,
    output logic [31:0]                   stall_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [SEL_W-1:0]      src_a;
        logic [SEL_W-1:0]      src_b;
        logic [2:0]            op;
        logic [DATA_WIDTH-1:0] cnst;
        logic [NUM_OUT-1:0]    mask;
        logic [7:0]            rpt;
    } cfg_t;

    // Handshake: a token moves on any channel when valid=1 and stop=0 in the same cycle.
    cfg_t                  cfg_mem [CTX_DEPTH];
    cfg_t                  cur;
    cfg_t                  wr_word;
    logic [CTX_W-1:0]      ctx;
    logic [CTX_W-1:0]      last_ctx_q;
    logic [7:0]            rep_cnt;
    logic                  running;
    logic [DATA_WIDTH-1:0] loc_reg;

    logic [DATA_WIDTH-1:0] fifo_data [BUF_DEPTH];
    logic [NUM_OUT-1:0]    fifo_mask [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [NUM_OUT-1:0]    sent;

    logic                  va, vb, fire, pop, head_valid, fifo_full;
    logic [DATA_WIDTH-1:0] a, b, result, head_data;
    logic [NUM_OUT-1:0]    head_mask, accepted;

    assign cur     = cfg_mem[ctx];
    assign wr_word = '{src_a: cfg_src_a, src_b: cfg_src_b, op: cfg_op, cnst: cfg_const,
                       mask: cfg_out_mask, rpt: cfg_repeat};

    // Operand select: neighbours first, then local register, then constant; anything else never valid.
    always_comb begin
        va = 1'b0;
        vb = 1'b0;
        a  = '0;
        b  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cur.src_a == SEL_W'(i)) begin
                va = in_valid[i];
                a  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (cur.src_b == SEL_W'(i)) begin
                vb = in_valid[i];
                b  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (cur.src_a == SEL_W'(NUM_IN))     begin va = 1'b1; a = loc_reg;  end
        if (cur.src_a == SEL_W'(NUM_IN + 1)) begin va = 1'b1; a = cur.cnst; end
        if (cur.src_b == SEL_W'(NUM_IN))     begin vb = 1'b1; b = loc_reg;  end
        if (cur.src_b == SEL_W'(NUM_IN + 1)) begin vb = 1'b1; b = cur.cnst; end
    end

    always_comb begin
        result = '0;
        case (cur.op)
            3'd0: result = a + b;
            3'd1: result = a - b;
            3'd2: result = a * b;
            3'd3: result = a & b;
            3'd4: result = a | b;
            3'd5: result = a ^ b;
            3'd6: result = a;
            default: result = cur.cnst;
        endcase
    end

    assign fifo_full  = (count == CNT_W'(BUF_DEPTH));
    assign head_valid = (count != '0);
    assign head_data  = fifo_data[rd_ptr];
    assign head_mask  = fifo_mask[rd_ptr];
    assign fire       = running & ~halt & ~start & va & vb & ~fifo_full;

    always_comb begin
        in_stop = '1;
        for (int i = 0; i < NUM_IN; i++) begin
            in_stop[i] = ~(fire & ((cur.src_a == SEL_W'(i)) | (cur.src_b == SEL_W'(i))));
        end
    end

    // Eager fork: each masked output takes the head once; the head pops when all have it.
    assign out_valid = {NUM_OUT{head_valid}} & head_mask & ~sent;
    assign accepted  = out_valid & ~out_stop;
    assign pop       = head_valid & ((head_mask & ~(sent | accepted)) == '0);
    assign out_data  = {NUM_OUT{head_valid ? head_data : {DATA_WIDTH{1'b0}}}};
    assign ctx_id    = ctx;
    assign busy      = running | head_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CTX_DEPTH; i++) cfg_mem[i] <= '0;
        end else if (cfg_we) begin
            cfg_mem[cfg_addr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctx         <= '0;
            last_ctx_q  <= '0;
            rep_cnt     <= '0;
            running     <= 1'b0;
            loc_reg     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sent        <= '0;
            fire_count  <= '0;
            stall_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_mask[i] <= '0;
            end
        end else if (start) begin
            ctx         <= '0;
            rep_cnt     <= '0;
            running     <= 1'b1;
            last_ctx_q  <= last_ctx;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sent        <= '0;
            fire_count  <= '0;
            stall_count <= '0;
        end else begin
            if (fire) begin
                fifo_data[wr_ptr] <= result;
                fifo_mask[wr_ptr] <= cur.mask;
                wr_ptr            <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                loc_reg           <= result;
                fire_count        <= fire_count + 32'd1;
                if (rep_cnt == cur.rpt) begin
                    rep_cnt <= '0;
                    ctx     <= (ctx == last_ctx_q) ? '0 : ctx + CTX_W'(1);
                end else begin
                    rep_cnt <= rep_cnt + 8'd1;
                end
            end
            if (running && !halt && !fire) stall_count <= stall_count + 32'd1;
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                sent   <= '0;
            end else begin
                sent <= sent | accepted;
            end
            if (fire && !pop)      count <= count + CNT_W'(1);
            else if (!fire && pop) count <= count - CNT_W'(1);
        end
    end

endmodule
